// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch responder: state encodings,
// the fault NOP word and a small alignment helper.
package instr_fetch_unit_pkg;

  // Fetch FSM encodings, kept as plain constants so legacy benches can reuse them.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // MOV r0,r0: returned in IR whenever a fetch faults.
  localparam logic [31:0] NopInsnDefault = 32'hE1A00000;

  // Instruction fetches must be word aligned.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: accepts a fetch request from the control FSM, runs one req/ack
// read on instruction memory and presents the word on IR with a one-cycle W_IR_valid pulse.
// Branch flushes drain the outstanding read; misaligned PCs and bus timeouts return a NOP.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(NopInsnDefault)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] IR,
  output logic              W_IR_valid,
  output logic              fetch_fault,
  output logic              busy
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [TimerW-1:0] timer_q, timer_d;

  // Next-state logic: the timer counts every cycle the read is outstanding, so a flushed read
  // that is still un-acked gives up once the whole transaction has aged TIMEOUT cycles.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    valid_d    = 1'b0;
    fault_d    = 1'b0;
    timer_d    = timer_q;
    case (state_q)
      StIdle: begin
        if (fetch_req) begin
          if (!is_word_aligned(pc_addr[1:0])) begin
            state_d = StDone;
            ir_d    = NOP_INSN;
            valid_d = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d    = StWait;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_addr;
            timer_d    = '0;
          end
        end
      end
      StWait: begin
        if (flush) begin
          if (mem_ack) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
          end else begin
            // Request must stay up until the memory acks.
            state_d = StDrain;
            timer_d = timer_q + TimerW'(1);
          end
        end else if (mem_ack) begin
          state_d   = StDone;
          ir_d      = mem_rdata;
          valid_d   = 1'b1;
          mem_req_d = 1'b0;
        end else if (timer_q == TimerLast) begin
          state_d   = StDone;
          ir_d      = NOP_INSN;
          valid_d   = 1'b1;
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDrain: begin
        // >= because a flush in the last WAIT cycle pushes the timer one past TimerLast.
        if (mem_ack || (timer_q >= TimerLast)) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      timer_q    <= timer_d;
    end
  end

  // Output mapping; busy is decoded straight from state.
  always_comb begin
    mem_req     = mem_req_q;
    mem_addr    = mem_addr_q;
    IR          = ir_q;
    W_IR_valid  = valid_q;
    fetch_fault = fault_q;
    busy        = (state_q != StIdle);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a transaction-level model (age of the outstanding read).
module tb_instr_fetch_unit;

  localparam int unsigned T   = 8;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] pc_addr;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic        fetch_fault;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  instr_fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (T),
    .NOP_INSN(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc_addr    (pc_addr),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .IR         (IR),
    .W_IR_valid (W_IR_valid),
    .fetch_fault(fetch_fault),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one outstanding read tracked by its age (1 = first cycle mem_req is high).
  logic        m_active, m_flushed, m_valid, m_fault;
  logic [31:0] m_addr, m_ir;
  int          m_age;

  always @(posedge clk) begin
    if (rst) begin
      m_active  <= 1'b0;
      m_flushed <= 1'b0;
      m_valid   <= 1'b0;
      m_fault   <= 1'b0;
      m_addr    <= '0;
      m_ir      <= '0;
      m_age     <= 0;
    end else begin
      m_valid <= 1'b0;
      m_fault <= 1'b0;
      if (m_valid) begin
        // delivery cycle: inputs ignored
      end else if (!m_active) begin
        if (fetch_req) begin
          if (pc_addr[1:0] != 2'b00) begin
            m_valid <= 1'b1;
            m_fault <= 1'b1;
            m_ir    <= NOP;
          end else begin
            m_active  <= 1'b1;
            m_flushed <= 1'b0;
            m_age     <= 1;
            m_addr    <= pc_addr;
          end
        end
      end else if (!m_flushed) begin
        if (flush) begin
          if (mem_ack) m_active <= 1'b0;
          else begin
            m_flushed <= 1'b1;
            m_age     <= m_age + 1;
          end
        end else if (mem_ack) begin
          m_active <= 1'b0;
          m_valid  <= 1'b1;
          m_ir     <= mem_rdata;
        end else if (m_age == T) begin
          m_active <= 1'b0;
          m_valid  <= 1'b1;
          m_fault  <= 1'b1;
          m_ir     <= NOP;
        end else begin
          m_age <= m_age + 1;
        end
      end else begin
        if (mem_ack || m_age >= T) m_active <= 1'b0;
        else m_age <= m_age + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_mem_req", {31'd0, mem_req}, {31'd0, m_active});
      chk("m_mem_addr", mem_addr, m_addr);
      chk("m_ir", IR, m_ir);
      chk("m_valid", {31'd0, W_IR_valid}, {31'd0, m_valid});
      chk("m_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      chk("m_busy", {31'd0, busy}, {31'd0, m_active | m_valid});
    end
  end

  int   reads, valids;
  logic prev_req;

  initial begin
    rst = 1'b1; fetch_req = 1'b0; pc_addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_ir", IR, 32'd0);
    chk("rst_valid", {31'd0, W_IR_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;

    // Plain fetch, ack in the first WAIT cycle.
    fetch_req = 1'b1; pc_addr = 32'h100;
    step();
    fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hEA000004;
    @(negedge clk);
    chk("plain_req", {31'd0, mem_req}, 32'd1);
    chk("plain_addr", mem_addr, 32'h100);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("plain_valid", {31'd0, W_IR_valid}, 32'd1);
    chk("plain_ir", IR, 32'hEA000004);
    chk("plain_fault", {31'd0, fetch_fault}, 32'd0);
    step();
    @(negedge clk);
    chk("plain_pulse", {31'd0, W_IR_valid}, 32'd0);

    // Misaligned PC: no memory access, NOP with fault next cycle.
    fetch_req = 1'b1; pc_addr = 32'h102;
    step();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("mis_valid", {31'd0, W_IR_valid}, 32'd1);
    chk("mis_ir", IR, NOP);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    step();

    // Timeout: no ack for T WAIT cycles.
    fetch_req = 1'b1; pc_addr = 32'h300;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < int'(T); i++) begin
      @(negedge clk);
      chk("to_req_held", {31'd0, mem_req}, 32'd1);
      step();
    end
    @(negedge clk);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_valid", {31'd0, W_IR_valid}, 32'd1);
    chk("to_ir", IR, NOP);
    chk("to_fault", {31'd0, fetch_fault}, 32'd1);
    step();

    // Flush two cycles into WAIT; late ack drains silently.
    fetch_req = 1'b1; pc_addr = 32'h400;
    step();
    fetch_req = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_req_held", {31'd0, mem_req}, 32'd1);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("fl_req_ack", {31'd0, mem_req}, 32'd1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("fl_req_drop", {31'd0, mem_req}, 32'd0);
    chk("fl_no_valid", {31'd0, W_IR_valid}, 32'd0);
    chk("fl_ir_kept", IR, NOP);
    fetch_req = 1'b1; pc_addr = 32'h200;
    step();
    fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("fl_next_addr", mem_addr, 32'h200);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("fl_next_valid", {31'd0, W_IR_valid}, 32'd1);
    chk("fl_next_ir", IR, 32'h12345678);
    step();

    // Held request: one read, one delivery.
    reads = 0; valids = 0; prev_req = mem_req;
    for (int c = 0; c < 10; c++) begin
      fetch_req = (c < 6); pc_addr = 32'h500; mem_ack = (c == 4); mem_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      if (mem_req && !prev_req) reads++;
      prev_req = mem_req;
      if (W_IR_valid) valids++;
      step();
    end
    fetch_req = 1'b0; mem_ack = 1'b0;
    chk("held_reads", reads, 32'd1);
    chk("held_valids", valids, 32'd1);
    chk("held_ir", IR, 32'hA5A5A5A5);

    // Reset during WAIT, then a stray ack.
    fetch_req = 1'b1; pc_addr = 32'h600;
    step();
    fetch_req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_req", {31'd0, mem_req}, 32'd0);
    chk("rw_addr", mem_addr, 32'd0);
    chk("rw_ir", IR, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rw_late_valid", {31'd0, W_IR_valid}, 32'd0);
    chk("rw_late_busy", {31'd0, busy}, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      step();
      rst       = ($urandom_range(0, 199) == 0);
      fetch_req = ($urandom_range(0, 2) != 0);
      pc_addr   = $urandom;
      if ($urandom_range(0, 7) != 0) pc_addr[1:0] = 2'b00;
      flush     = ($urandom_range(0, 15) == 0);
      mem_ack   = m_active ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata = $urandom;
    end
    step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
